// File: rtl/sync_ram_pkg.sv
// sync_ram_pkg
//    Shared constants for the sync_ram block: default geometry and a helper
//    that turns an address width into a word count.
package sync_ram_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 4;

   function automatic int ram_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/sync_ram_array.sv
// sync_ram_array
//    Storage array plus write port for sync_ram, with combinational read of
//    the addressed word (the top level registers it).
//
//    Build option: SYNC_RAM_MEM_CLEAR_EN
//       defined   - every word is cleared to 0 at each edge where rst is high
//       undefined - rst only blocks writes; contents survive reset and the
//                   array is free to map onto inferred block RAM
//
// Ports
//    clk       in   clock, rising edge
//    rst       in   synchronous active-high reset
//    we        in   write enable
//    addr      in   word address
//    wr_data   in   write data
//    rd_data   out  current contents of mem[addr]
module sync_ram_array
   import sync_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = ram_depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

`ifdef SYNC_RAM_MEM_CLEAR_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[addr] <= wr_data;
      end
   end
`else
   // No reset branch on the storage itself, so tools can infer block RAM;
   // rst only suppresses a write presented in the reset cycle.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         r_mem[addr] <= wr_data;
      end
   end
`endif

   assign rd_data = r_mem[addr];

endmodule

// File: rtl/sync_ram.sv
// sync_ram
//    Single-port synchronous RAM with a registered, write-first read output.
//    One address bus serves reads and writes; read latency is one cycle.
//
//    Build option: SYNC_RAM_MEM_CLEAR_EN (see sync_ram_array) selects whether
//    reset also clears the memory contents.
//
// Ports
//    clk       in   clock, rising edge
//    rst       in   synchronous active-high reset, clears data_out
//    we        in   1 = write data_in to mem[addr], 0 = read mem[addr]
//    data_in   in   write data
//    addr      in   word address for both read and write
//    data_out  out  registered read data
module sync_ram
   import sync_ram_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [DATA_WIDTH-1:0] r_data_out;

   sync_ram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .addr    (addr),
      .wr_data (data_in),
      .rd_data (w_rd_data)
   );

   // Write-first: on a write the new word bypasses the array straight into
   // the output register, so the caller sees it after the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_out <= '0;
      end else if (we) begin
         r_data_out <= data_in;
      end else begin
         r_data_out <= w_rd_data;
      end
   end

   assign data_out = r_data_out;

endmodule

// File: tb/tb_sync_ram.sv
// tb_sync_ram
//    Self-checking bench for sync_ram (default 8-bit x 16 words). Expected
//    read data comes from a plain array model with per-word "known" flags;
//    reads of never-written words (no clear) are not compared.
module tb_sync_ram;

   logic       clk;
   logic       rst;
   logic       we;
   logic [7:0] data_in;
   logic [3:0] addr;
   logic [7:0] data_out;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] mdl [16];
   bit         vld [16];
   logic [3:0] wr_addrs [$];

   sync_ram #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .data_in  (data_in),
      .addr     (addr),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus, update the model, and compare data_out
   // just after the edge.
   task automatic op(input bit r, input bit w, input logic [3:0] a,
                     input logic [7:0] d, input string tag);
      logic [7:0] exp;
      bit         known;
      rst     = r;
      we      = w;
      addr    = a;
      data_in = d;
      if (r) begin
         exp   = 8'h00;
         known = 1'b1;
`ifdef SYNC_RAM_MEM_CLEAR_EN
         for (int i = 0; i < 16; i++) begin
            mdl[i] = 8'h00;
            vld[i] = 1'b1;
         end
`endif
      end else if (w) begin
         mdl[a] = d;
         vld[a] = 1'b1;
         exp    = d;
         known  = 1'b1;
      end else begin
         exp   = mdl[a];
         known = vld[a];
      end
      @(posedge clk);
      #1;
      if (known) chk(tag, data_out, exp);
   endtask

   initial begin
      logic [7:0] held;
      for (int i = 0; i < 16; i++) begin
         mdl[i] = 8'h00;
         vld[i] = 1'b0;
      end
      rst = 1'b0; we = 1'b0; addr = '0; data_in = '0;
      #1;

      op(1, 0, 4'h0, 8'h00, "reset");
`ifdef SYNC_RAM_MEM_CLEAR_EN
      op(0, 0, 4'h7, 8'h00, "clear_rd7");
`endif

      op(0, 1, 4'h3, 8'hA5, "wr3");
      op(0, 1, 4'hF, 8'h3C, "wrF");
      op(0, 0, 4'h3, 8'h00, "rd3");
      op(0, 0, 4'hF, 8'h00, "rdF");

      op(0, 1, 4'h9, 8'h81, "wr_first");

      op(0, 1, 4'h5, 8'h11, "ovw1");
      op(0, 1, 4'h5, 8'h22, "ovw2");
      op(0, 0, 4'h5, 8'h00, "ovw_rd");

      // data_out must hold between edges whatever the inputs do
      held    = data_out;
      addr    = 4'h3;
      we      = 1'b1;
      data_in = 8'h77;
      #3;
      chk("hold", data_out, held);
      we = 1'b0;

      op(0, 1, 4'h2, 8'h5A, "pre_wr2");
      op(1, 1, 4'h2, 8'hFF, "rst_wr");
      op(0, 0, 4'h2, 8'h00, "rst_blk_rd2");
      chk("rst_blk_not_ff", {7'd0, data_out === 8'hFF}, 8'h00);

      for (int round = 0; round < 4; round++) begin
         for (int k = 0; k < 5; k++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            wr_addrs.push_back(a);
            op(0, 1, a, 8'($urandom), "rnd_wr");
         end
         for (int k = 0; k < 5; k++) begin
            logic [3:0] a;
            a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
            op(0, 0, a, 8'($urandom), "rnd_rd");
         end
      end

      op(0, 0, 4'h9, 8'h00, "final_rd9");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
